// File: rtl/mem_pkg.sv
// Shared types for the memory request unit: FSM states, bus op and full byte-enable mask.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA_ACC  = 2'd1,
      FETCH_ACC = 2'd2,
      RESP      = 2'd3
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: counts bus wait cycles and flags when the wait budget is spent.
// Latency: expired is combinational from the registered count (TIMEOUT_CYCLES-1 enabled edges).
// Backpressure: none; holds at the expired value until cleared.
module bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_request_unit.sv
// Purpose: arbitrates core fetch/load/store onto a single-outstanding memory bus; optional
// Latency: min 2 cycles request-to-valid (1 on a fetch-buffer hit, MEM_REQ_FETCH_BUF_EN).
// Backpressure: bus_ready stalls the transaction, cpu_busy stalls the core; timeout aborts.
module mem_request_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              data_read_req,
   input  logic              data_write_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   input  logic [3:0]        data_be,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic [DATA_W-1:0] instr_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_valid,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_be,
   output logic              bus_read,
   output logic              bus_write,
   output logic              bus_error
);

   state_t state;
   op_t    op;
   logic   in_acc;
   logic   tmo_expired;
   logic   data_req;
   logic   fetch_hit;

   assign in_acc   = (state == DATA_ACC) || (state == FETCH_ACC);
   assign data_req = data_read_req || data_write_req;

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clear  (!in_acc),
      .enable (in_acc && !bus_ready),
      .expired(tmo_expired)
   );

`ifdef MEM_REQ_FETCH_BUF_EN
   logic              buf_vld;
   logic [ADDR_W-1:0] buf_tag;
   logic [DATA_W-1:0] buf_word;

   assign fetch_hit = buf_vld && (buf_tag == instr_addr);

   // Refill only on a real bus completion, never on a timeout abort.
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_vld  <= 1'b0;
         buf_tag  <= '0;
         buf_word <= '0;
      end else if (state == IDLE && data_write_req && data_addr == buf_tag) begin
         buf_vld <= 1'b0;
      end else if (state == FETCH_ACC && bus_ready) begin
         buf_vld  <= 1'b1;
         buf_tag  <= bus_addr;
         buf_word <= bus_rdata;
      end
   end
`else
   assign fetch_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         op          <= OP_READ;
         instr_rdata <= '0;
         instr_valid <= 1'b0;
         data_rdata  <= '0;
         data_valid  <= 1'b0;
         cpu_busy    <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_be      <= '0;
         bus_read    <= 1'b0;
         bus_write   <= 1'b0;
         bus_error   <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         data_valid  <= 1'b0;
         bus_error   <= 1'b0;
         case (state)
            IDLE: begin
               if (data_req) begin
                  // A simultaneous read and write resolves to the write.
                  op        <= data_write_req ? OP_WRITE : OP_READ;
                  bus_addr  <= data_addr;
                  bus_wdata <= data_write_req ? data_wdata : '0;
                  bus_be    <= data_write_req ? data_be : BE_FULL;
                  bus_read  <= !data_write_req;
                  bus_write <= data_write_req;
                  cpu_busy  <= 1'b1;
                  state     <= DATA_ACC;
               end else if (instr_req && fetch_hit) begin
`ifdef MEM_REQ_FETCH_BUF_EN
                  instr_rdata <= buf_word;
`endif
                  instr_valid <= 1'b1;
                  cpu_busy    <= 1'b1;
                  state       <= RESP;
               end else if (instr_req) begin
                  op        <= OP_READ;
                  bus_addr  <= instr_addr;
                  bus_wdata <= '0;
                  bus_be    <= BE_FULL;
                  bus_read  <= 1'b1;
                  cpu_busy  <= 1'b1;
                  state     <= FETCH_ACC;
               end
            end
            DATA_ACC, FETCH_ACC: begin
               if (bus_ready || tmo_expired) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  bus_error <= !bus_ready;
                  state     <= RESP;
                  if (state == FETCH_ACC) begin
                     instr_valid <= 1'b1;
                     instr_rdata <= bus_ready ? bus_rdata : '0;
                  end else begin
                     data_valid <= 1'b1;
                     data_rdata <= (bus_ready && op == OP_READ) ? bus_rdata : '0;
                  end
               end
            end
            RESP: begin
               cpu_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a bus responder and a response scoreboard.
module tb_mem_request_unit;

   typedef struct {
      bit          fetch;
      logic [31:0] data;
      bit          err;
   } exp_t;

`ifdef MEM_REQ_FETCH_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, data_read_req, data_write_req;
   logic [31:0] instr_addr, data_addr, data_wdata;
   logic [3:0]  data_be;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic [31:0] instr_rdata, data_rdata, bus_addr, bus_wdata;
   logic        instr_valid, data_valid, cpu_busy, bus_read, bus_write, bus_error;
   logic [3:0]  bus_be;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int ready_delay = 0;
   int wait_cnt = 0;
   int rd_cycles = 0, wr_cycles = 0, rd_starts = 0, unstable = 0;
   logic [31:0] last_rd_addr = '0;
   exp_t sbq[$];

   mem_request_unit dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .data_read_req(data_read_req), .data_write_req(data_write_req),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .instr_rdata(instr_rdata), .instr_valid(instr_valid),
      .data_rdata(data_rdata), .data_valid(data_valid), .cpu_busy(cpu_busy),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_read(bus_read), .bus_write(bus_write), .bus_error(bus_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h0020_8193;
         32'h0000_0004: return 32'h0000_0001;
         default:       return a ^ 32'hA5A5_0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus responder: asserts bus_ready after ready_delay wait cycles of an active strobe.
   always @(negedge clk) begin
      if (bus_read || bus_write) begin
         bus_ready = (wait_cnt == ready_delay);
         bus_rdata = mem_rd(bus_addr);
         wait_cnt++;
      end else begin
         bus_ready = 1'b0;
         bus_rdata = '0;
         wait_cnt  = 0;
      end
   end

   // Monitor: strobe accounting, stability of latched values, scoreboard on valid pulses.
   logic        prev_strobe = 1'b0, prev_rd = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;
   logic [3:0]  prev_be = '0;
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      if (bus_read) rd_cycles++;
      if (bus_write) wr_cycles++;
      if (bus_read && !prev_rd) begin
         rd_starts++;
         last_rd_addr = bus_addr;
      end
      if ((bus_read || bus_write) && prev_strobe &&
          (bus_addr != prev_addr || bus_wdata != prev_wdata || bus_be != prev_be))
         unstable++;
      if (instr_valid || data_valid) begin
         have = (sbq.size() != 0);
         check("scoreboard has entry", have, 1);
         if (have) begin
            e = sbq.pop_front();
            check("valid kind", instr_valid, e.fetch);
            check("valid exclusive", instr_valid && data_valid, 0);
            check("rdata", e.fetch ? instr_rdata : data_rdata, e.data);
            check("bus_error with valid", bus_error, e.err);
         end
      end else begin
         check("bus_error without valid", bus_error, 0);
      end
      prev_strobe = bus_read || bus_write;
      prev_rd     = bus_read;
      prev_addr   = bus_addr;
      prev_wdata  = bus_wdata;
      prev_be     = bus_be;
   end

   task automatic push(input bit fetch, input logic [31:0] data, input bit err);
      exp_t e;
      e.fetch = fetch;
      e.data  = data;
      e.err   = err;
      sbq.push_back(e);
   endtask

   task automatic wait_valid(input bit fetch, input string tag);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = fetch ? instr_valid : data_valid;
      end
      check(tag, seen, 1);
   endtask

   task automatic do_fetch(input logic [31:0] a, output int lat);
      int t;
      @(posedge clk); #1;
      instr_addr = a;
      instr_req  = 1'b1;
      push(1, mem_rd(a), 0);
      t = cycle;
      wait_valid(1, "fetch valid seen");
      instr_req = 1'b0;
      lat = cycle - t;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(posedge clk); #1;
      data_addr      = a;
      data_wdata     = d;
      data_be        = be;
      data_write_req = 1'b1;
      push(0, 32'h0, 0);
      wait_valid(0, "store valid seen");
      data_write_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, dc, r0, w0, u0, lat;
      rst = 1'b0;
      instr_req = 0; data_read_req = 0; data_write_req = 0;
      instr_addr = 0; data_addr = 0; data_wdata = 0; data_be = 0;
      bus_ready = 0; bus_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs zero", |{instr_rdata, instr_valid, data_rdata, data_valid, cpu_busy,
                                    bus_addr, bus_wdata, bus_be, bus_read, bus_write, bus_error}, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Fetch with zero wait states
      ready_delay = 0;
      r0 = rd_cycles;
      @(posedge clk); #1;
      instr_addr = 32'h10;
      instr_req  = 1'b1;
      push(1, 32'h0020_8193, 0);
      t0 = cycle;
      @(negedge clk);
      @(negedge clk);
      check("fetch strobe", bus_read, 1);
      check("fetch addr", bus_addr, 32'h10);
      check("fetch be", bus_be, 4'hF);
      check("fetch busy", cpu_busy, 1);
      wait_valid(1, "fetch1 valid seen");
      instr_req = 1'b0;
      check("fetch latency", cycle - t0, 2);
      check("fetch read cycles", rd_cycles - r0, 1);

      // Data has priority over a simultaneous fetch
      @(posedge clk); #1;
      instr_addr    = 32'h100;
      data_addr     = 32'h4;
      instr_req     = 1'b1;
      data_read_req = 1'b1;
      push(0, 32'h1, 0);
      push(1, mem_rd(32'h100), 0);
      wait_valid(0, "prio data valid seen");
      data_read_req = 1'b0;
      dc = cycle;
      check("prio first addr", last_rd_addr, 32'h4);
      @(negedge clk);
      check("prio idle gap busy", cpu_busy, 0);
      check("prio idle gap strobe", bus_read, 0);
      wait_valid(1, "prio fetch valid seen");
      instr_req = 1'b0;
      check("prio fetch spacing", cycle - dc, 3);
      check("prio fetch addr", last_rd_addr, 32'h100);

      // Store with three wait states
      ready_delay = 3;
      r0 = rd_cycles; w0 = wr_cycles; u0 = unstable;
      @(posedge clk); #1;
      data_addr = 32'h8; data_wdata = 32'h1E; data_be = 4'hF;
      data_write_req = 1'b1;
      push(0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      check("store strobe", bus_write, 1);
      check("store addr", bus_addr, 32'h8);
      check("store wdata", bus_wdata, 32'h1E);
      wait_valid(0, "store valid seen");
      data_write_req = 1'b0;
      check("store write cycles", wr_cycles - w0, 4);
      check("store no read", rd_cycles - r0, 0);
      check("store stable", unstable - u0, 0);

      // Read and write together: write wins, partial byte enables latched
      ready_delay = 1;
      r0 = rd_cycles;
      @(posedge clk); #1;
      data_addr = 32'hC; data_wdata = 32'hDEAD; data_be = 4'h5;
      data_read_req = 1'b1; data_write_req = 1'b1;
      push(0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      check("rw write strobe", bus_write, 1);
      check("rw be", bus_be, 4'h5);
      wait_valid(0, "rw valid seen");
      data_read_req = 1'b0; data_write_req = 1'b0;
      check("rw no read", rd_cycles - r0, 0);

      // Bus never answers: timeout
      ready_delay = 1000;
      r0 = rd_cycles;
      @(posedge clk); #1;
      data_addr = 32'h20;
      data_read_req = 1'b1;
      push(0, 32'h0, 1);
      wait_valid(0, "timeout valid seen");
      data_read_req = 1'b0;
      check("timeout strobe cycles", rd_cycles - r0, 16);
      @(negedge clk);
      check("timeout back idle", cpu_busy, 0);

      // Request dropped mid-transaction still completes
      ready_delay = 2;
      @(posedge clk); #1;
      data_addr = 32'h4;
      data_read_req = 1'b1;
      push(0, 32'h1, 0);
      @(negedge clk);
      @(negedge clk);
      data_read_req = 1'b0;
      wait_valid(0, "dropped req valid seen");

      // Reset during DATA_ACC aborts silently
      ready_delay = 1000;
      @(posedge clk); #1;
      data_addr = 32'h30;
      data_read_req = 1'b1;
      repeat (3) @(negedge clk);
      check("abort strobe before reset", bus_read, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      data_read_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort strobes", bus_read || bus_write, 0);
      check("abort busy", cpu_busy, 0);
      check("abort no valid", instr_valid || data_valid, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      ready_delay = 0;
      do_fetch(32'h10, lat);
      check("post reset fetch latency", lat, 2);

      // Fetch buffer behaviour (bus used every time when the buffer is absent)
      do_store(32'h10, 32'h55, 4'hF);
      r0 = rd_starts;
      do_fetch(32'h10, lat);
      check("buf first fetch reads", rd_starts - r0, 1);
      r0 = rd_starts;
      do_fetch(32'h10, lat);
      check("buf repeat fetch reads", rd_starts - r0, BUF_EN ? 0 : 1);
      check("buf repeat fetch latency", lat, BUF_EN ? 1 : 2);
      do_store(32'h10, 32'h66, 4'hF);
      r0 = rd_starts;
      do_fetch(32'h10, lat);
      check("buf fetch after store reads", rd_starts - r0, 1);

      repeat (3) @(negedge clk);
      check("scoreboard drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sits directly downstream of cpu_core, between the core's fetch/load/store requests and the shared memory bus.
- Arbitrates between instruction fetch and data access and drives a single-outstanding bus transaction.
- Holds request address, data and byte enables stable until the bus acknowledges.
- Returns read data to the core with one-cycle valid pulses; a timeout counter covers a non-responding bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, bus-wait cycles before abort; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset; 0 at a rising edge resets.
- instr_req  in  1  fetch request; level, held until instr_valid.
- instr_addr  in  ADDR_W  fetch address.
- data_read_req  in  1  load request; level, held until data_valid.
- data_write_req  in  1  store request; level, held until data_valid.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_be  in  4  store byte enables.
- bus_rdata  in  DATA_W  read data from bus.
- bus_ready  in  1  bus completes the current transaction this cycle.
- instr_rdata  out  DATA_W  fetched instruction.
- instr_valid  out  1  one-cycle pulse; instr_rdata valid.
- data_rdata  out  DATA_W  load data.
- data_valid  out  1  one-cycle pulse; load or store complete.
- cpu_busy  out  1  unit not idle; core stalls.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  write data.
- bus_be  out  4  byte enables; 4'hF on reads.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=0 at edge): state IDLE. All outputs 0, timeout counter 0, latched request cleared. Reset mid-transaction aborts it with no valid pulse.
- FSM states: IDLE, DATA_ACC, FETCH_ACC, RESP.
- IDLE: at each edge, sample requests.
  - Any data request present -> DATA_ACC.
  - Otherwise instr_req -> FETCH_ACC.
  - Data always has priority over fetch.
  - data_read_req and data_write_req both high: write performed, read ignored.
- On acceptance, latch the address, wdata, be and op.
  - From the next cycle, bus_read or bus_write is high with latched values.
  - Latched values stay stable until the strobe drops.
- DATA_ACC / FETCH_ACC: wait for bus_ready.
  - Edge with bus_ready=1: capture bus_rdata (reads only), drop strobes, go to RESP.
  - Each edge with bus_ready=0: increment the timeout counter.
  - Counter reaching TIMEOUT_CYCLES-1 with no bus_ready: drop strobes, set response data to 0, pulse bus_error in RESP.
- RESP (one cycle): pulse instr_valid or data_valid together with rdata, then go to IDLE.
  - Store: data_valid pulses, data_rdata=0.
  - A pending instr_req is taken on the following IDLE edge, so back-to-back transactions are separated by one IDLE cycle.
- Minimum latency: request accepted at edge 0, strobe high in cycle 1, bus_ready in cycle 1, valid in cycle 2.
- cpu_busy is registered: 1 in DATA_ACC, FETCH_ACC and RESP; 0 in IDLE.
- Request deasserted mid-transaction: the transaction still completes and the valid pulse is still issued.
- instr_rdata and data_rdata hold their last value between pulses.

Optional Feature:
- Macro: MEM_REQ_FETCH_BUF_EN.
- Defined: single-entry fetch buffer holding tag (address), word and valid bit.
  - In IDLE, an instr_req with no data request and a matching valid tag goes straight to RESP with no bus access; instr_valid arrives the next cycle.
  - Any store whose address matches the tag clears the valid bit.
  - Reset clears the valid bit.
- Undefined: every fetch uses the bus.

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE, DATA_ACC, FETCH_ACC, RESP);
  - op typedef (OP_READ, OP_WRITE);
  - BE_FULL=4'hF.
- One sub-module, bus_timeout_counter: clear, enable, expired output, parameterized TIMEOUT_CYCLES.

Test Plan:
- Fetch at 0x0000_0010, bus_ready in the first strobe cycle with bus_rdata=0x0020_8193 -> bus_read=1 for 1 cycle, instr_valid pulses 2 cycles after the request with instr_rdata=0x0020_8193.
- instr_req and data_read_req at 0x0000_0004 in the same cycle -> data read on the bus first; data_valid with 0x0000_0001, then one IDLE cycle, then the fetch; instr_valid follows.
- Store 0x0000_001E to 0x0000_0008 with be=4'hF, bus_ready after 3 wait cycles -> bus_write high 4 cycles with stable addr/wdata; data_valid pulses; bus_read never high.
- bus_ready held 0 with TIMEOUT_CYCLES=16 -> strobe drops after 16 cycles; bus_error and data_valid pulse together with data_rdata=0; state returns to IDLE.
- rst=0 during DATA_ACC -> next edge: bus strobes 0, cpu_busy 0, no valid pulse; a new fetch afterwards completes normally.
- With MEM_REQ_FETCH_BUF_EN: fetch 0x10 twice -> second fetch has no bus_read. A store to 0x10 between the fetches -> both fetches use the bus.
